uart_program_loader: RTL and testbench

UART_PROGRAM_LOADER -- requirements
Module: uart_program_loader

---
 rtl/uart_program_loader.sv | 140 ++++++++++++++
 tb/tb_uart_program_loader.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_program_loader.sv
// Receives 8N1 bytes, pairs them high-then-low into 16-bit words, and writes WORDS words to instruction memory.
// wr_en pulses the cycle after the low byte's stop sample; load_done latches one cycle after the final write.
module uart_program_loader #(
    parameter int CLKS_PER_BIT = 868,
    parameter int WORDS        = 32
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        UART_TXD_IN,
    output logic        wr_en,
    output logic [4:0]  wr_addr,
    output logic [15:0] wr_data,
    output logic        load_done,
    output logic        frame_err
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int CW = $clog2(WORDS + 1);
    localparam logic [BW-1:0] HALF_M1 = BW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0] FULL_M1 = BW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] WORDS_C = CW'(WORDS);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t         state_q;
    logic [BW-1:0]  baud_q;
    logic [2:0]     bit_idx_q;
    logic [7:0]     shift_q;
    logic           phase_q;
    logic [7:0]     hi_q;
    logic [CW-1:0]  wcnt_q;
    logic           rx_meta_q;
    logic           rx_s_q;
    logic           wr_en_q;
    logic [4:0]     wr_addr_q;
    logic [15:0]    wr_data_q;
    logic           load_done_q;
    logic           frame_err_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= UART_TXD_IN;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            baud_q      <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            phase_q     <= 1'b0;
            hi_q        <= '0;
            wcnt_q      <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            load_done_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            wr_en_q     <= 1'b0;
            frame_err_q <= 1'b0;
            if (wr_en_q && wcnt_q == WORDS_C) begin
                load_done_q <= 1'b1;
            end
            // Once loaded the receiver is parked; this also kills any frame begun in the final write's cycle.
            if (load_done_q) begin
                state_q <= IDLE;
                baud_q  <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        baud_q    <= '0;
                        bit_idx_q <= '0;
                        if (!rx_s_q) begin
                            state_q <= START;
                        end
                    end
                    START: begin
                        if (baud_q == HALF_M1) begin
                            baud_q    <= '0;
                            bit_idx_q <= '0;
                            state_q   <= rx_s_q ? IDLE : DATA;
                        end else begin
                            baud_q <= baud_q + 1'b1;
                        end
                    end
                    DATA: begin
                        if (baud_q == FULL_M1) begin
                            baud_q             <= '0;
                            shift_q[bit_idx_q] <= rx_s_q;
                            if (bit_idx_q == 3'd7) begin
                                state_q <= STOP;
                            end else begin
                                bit_idx_q <= bit_idx_q + 3'd1;
                            end
                        end else begin
                            baud_q <= baud_q + 1'b1;
                        end
                    end
                    STOP: begin
                        if (baud_q == FULL_M1) begin
                            baud_q  <= '0;
                            state_q <= IDLE;
                            // A bad stop bit drops the byte but leaves any pending high byte in place.
                            if (!rx_s_q) begin
                                frame_err_q <= 1'b1;
                            end else if (!phase_q) begin
                                hi_q    <= shift_q;
                                phase_q <= 1'b1;
                            end else begin
                                phase_q <= 1'b0;
                                if (wcnt_q != WORDS_C) begin
                                    wr_en_q   <= 1'b1;
                                    wr_addr_q <= 5'(wcnt_q);
                                    wr_data_q <= {hi_q, shift_q};
                                    wcnt_q    <= wcnt_q + 1'b1;
                                end
                            end
                        end else begin
                            baud_q <= baud_q + 1'b1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign load_done = load_done_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_program_loader.sv
// Drives 8N1 frames into the loader and checks every cycle against a byte-level model of word assembly.
module tb_uart_program_loader;

    localparam int CPB   = 4;
    localparam int WORDS = 4;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        UART_TXD_IN = 1'b1;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [15:0] wr_data;
    logic        load_done;
    logic        frame_err;

    uart_program_loader #(.CLKS_PER_BIT(CPB), .WORDS(WORDS)) dut (
        .CLK(CLK), .RST(RST), .UART_TXD_IN(UART_TXD_IN),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .load_done(load_done), .frame_err(frame_err)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    // Model state: expected writes {addr, data}, expected frame errors, byte phase.
    logic [20:0] exp_q[$];
    int          fe_exp  = 0;
    bit          m_phase = 0;
    logic [7:0]  m_hi    = '0;
    int          m_words = 0;

    // Observed state maintained by the compare process.
    int          fe_seen = 0;
    int          n_wr    = 0;
    bit          ld_armed = 0;
    logic [4:0]  lw_addr = '0;
    logic [15:0] lw_data = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, req);
        end
    endtask

    initial begin
        logic        r;
        logic        prev_we;
        logic        prev_fe;
        logic [20:0] e;
        prev_we = 1'b0;
        prev_fe = 1'b0;
        forever begin
            @(posedge CLK);
            r = RST;
            #1;
            if (r) begin
                check("rst wr_en", wr_en, 0);
                check("rst frame_err", frame_err, 0);
                check("rst load_done", load_done, 0);
                check("rst wr_addr", wr_addr, 0);
                check("rst wr_data", wr_data, 0);
                lw_addr = '0; lw_data = '0;
                ld_armed = 0; n_wr = 0; fe_seen = 0;
                prev_we = 1'b0; prev_fe = 1'b0;
            end else begin
                check("load_done", load_done, ld_armed);
                if (wr_en) begin
                    check("wr_en one cycle", prev_we, 0);
                    if (exp_q.size() == 0) begin
                        check("unexpected write", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("wr_addr", wr_addr, e[20:16]);
                        check("wr_data", wr_data, e[15:0]);
                    end
                    lw_addr = wr_addr;
                    lw_data = wr_data;
                    n_wr++;
                    if (n_wr == WORDS) ld_armed = 1;
                end else begin
                    check("wr_addr hold", wr_addr, lw_addr);
                    check("wr_data hold", wr_data, lw_data);
                end
                if (frame_err) begin
                    check("frame_err one cycle", prev_fe, 0);
                    fe_seen++;
                end
                prev_we = wr_en;
                prev_fe = frame_err;
            end
        end
    end

    task automatic do_reset(input int n);
        @(negedge CLK);
        RST = 1'b1;
        UART_TXD_IN = 1'b1;
        exp_q.delete();
        fe_exp = 0; m_phase = 0; m_hi = '0; m_words = 0;
        repeat (n) @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic drive_bit(input logic v);
        UART_TXD_IN = v;
        repeat (CPB) @(negedge CLK);
    endtask

    task automatic model_byte(input logic [7:0] b, input bit stop_ok);
        if (m_words < WORDS) begin
            if (!stop_ok) begin
                fe_exp++;
            end else if (!m_phase) begin
                m_hi = b;
                m_phase = 1;
            end else begin
                exp_q.push_back({5'(m_words), m_hi, b});
                m_words++;
                m_phase = 0;
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        model_byte(b, stop_ok);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop_ok);
        drive_bit(1'b1);
        drive_bit(1'b1);
    endtask

    task automatic settle_check(input string tag);
        repeat (12) @(negedge CLK);
        check({tag, " pending writes"}, exp_q.size(), 0);
        check({tag, " frame_err count"}, fe_seen, fe_exp);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] partial;
        int         nb;
        logic [7:0] rb;
        bit         rok;

        do_reset(4);
        check("reset wr_en", wr_en, 0);
        check("reset wr_addr", wr_addr, 0);
        check("reset load_done", load_done, 0);

        // Basic write
        send_byte(8'h12, 1); send_byte(8'h34, 1);
        settle_check("basic");
        check("basic n_wr", n_wr, 1);
        check("basic data", lw_data, 16'h1234);
        check("basic addr", lw_addr, 0);
        check("basic load_done", load_done, 0);

        // Glitch of one cycle
        do_reset(3);
        @(negedge CLK); UART_TXD_IN = 1'b0;
        @(negedge CLK); UART_TXD_IN = 1'b1;
        repeat (20) @(negedge CLK);
        settle_check("glitch");
        check("glitch n_wr", n_wr, 0);
        check("glitch frame_err", fe_seen, 0);

        // Frame errors, including one between high and low byte
        do_reset(3);
        send_byte(8'h55, 0);
        send_byte(8'hBE, 1); send_byte(8'hEF, 1);
        send_byte(8'h12, 1); send_byte(8'h00, 0); send_byte(8'h34, 1);
        settle_check("frame");
        check("frame fe count", fe_seen, 2);
        check("frame n_wr", n_wr, 2);
        check("frame last data", lw_data, 16'h1234);
        check("frame last addr", lw_addr, 1);

        // Reset during bit 3 of the low byte
        do_reset(3);
        send_byte(8'h77, 1);
        partial = 8'hF0;
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(partial[i]);
        UART_TXD_IN = partial[3];
        repeat (2) @(negedge CLK);
        do_reset(3);
        send_byte(8'hCA, 1); send_byte(8'hFE, 1);
        settle_check("midreset");
        check("midreset n_wr", n_wr, 1);
        check("midreset data", lw_data, 16'hCAFE);
        check("midreset addr", lw_addr, 0);

        // Full load, then bytes after done are ignored
        do_reset(3);
        for (int i = 1; i <= 4; i++) begin
            send_byte(8'hA0, 1);
            send_byte(8'(i), 1);
        end
        settle_check("full");
        check("full n_wr", n_wr, 4);
        check("full last data", lw_data, 16'hA004);
        check("full load_done", load_done, 1);
        send_byte(8'h99, 1); send_byte(8'h88, 0); send_byte(8'h77, 1);
        settle_check("postdone");
        check("postdone n_wr", n_wr, 4);
        check("postdone wr_addr", wr_addr, 3);
        check("postdone load_done", load_done, 1);

        // Random byte streams with occasional bad stop bits
        for (int it = 0; it < 3; it++) begin
            do_reset(3);
            nb = 8 + $urandom_range(0, 6);
            for (int k = 0; k < nb; k++) begin
                rb  = 8'($urandom_range(0, 255));
                rok = ($urandom_range(0, 4) != 0);
                send_byte(rb, rok);
            end
            settle_check("random");
            check("random load_done", load_done, (m_words == WORDS) ? 1 : 0);
            check("random n_wr", n_wr, m_words);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
